// File: rtl/instrumented_adder_counter.sv
// rtl/instrumented_adder_counter.sv - gated adder/inverter ring oscillator with ripple counter
// Measures loop transitions over a programmable clk window and hands the count back with a done pulse.

module instrumented_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  assign sum = a + b;
endmodule

module instrumented_adder_counter #(
  parameter int WIDTH         = 8,
  parameter int COUNT_W       = 16,
  parameter int GATE_W        = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int USE_EXT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [GATE_W-1:0]          gate_cycles,
  input  logic [WIDTH-1:0]           input_a,
  input  logic [WIDTH-1:0]           add_enable,
  input  logic [WIDTH-1:0]           xor_enable,
  input  logic [$clog2(WIDTH)-1:0]   tap_sel,
  input  logic                       ext_osc,
  output logic                       busy,
  output logic                       done,
  output logic [COUNT_W-1:0]         count,
  output logic                       overflow,
  output logic [WIDTH-1:0]           outputs
);
  localparam int SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SETTLE, CAPTURE} state_t;

  state_t                     state;
  logic [WIDTH-1:0]           a_r, add_r, xor_r;
  logic [$clog2(WIDTH)-1:0]   tap_r;
  logic [GATE_W-1:0]          gate_cnt;
  logic [SET_W-1:0]           settle_cnt;
  logic                       ring_en, ring_clr;

  logic [WIDTH-1:0]           sum;
  (* keep *) logic [WIDTH-1:0] loop;
  logic                       tap, cnt_clr, ring_ovf;
  logic [COUNT_W-1:0]         ring_cnt;

  instrumented_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (a_r),
    .b   (loop),
    .sum (sum)
  );

  assign outputs = (((add_r & sum) | (~add_r & loop)) ^ xor_r) & {WIDTH{ring_en}};
  assign loop    = ~outputs;

  // The external clock is gated so edges outside RUN never reach the counter; the ring stops by itself.
  assign tap     = (USE_EXT != 0) ? (ext_osc & ring_en) : loop[tap_r];
  assign cnt_clr = ring_clr | ~rst_n;

  for (genvar i = 0; i < COUNT_W; i++) begin : g_ripple
    logic q;
    if (i == 0) begin : g_first
      always_ff @(posedge tap or posedge cnt_clr) begin
        if (cnt_clr) q <= 1'b0;
        else         q <= ~q;
      end
    end else begin : g_next
      always_ff @(negedge ring_cnt[i-1] or posedge cnt_clr) begin
        if (cnt_clr) q <= 1'b0;
        else         q <= ~q;
      end
    end
    assign ring_cnt[i] = q;
  end

  always_ff @(negedge ring_cnt[COUNT_W-1] or posedge cnt_clr) begin
    if (cnt_clr) ring_ovf <= 1'b0;
    else         ring_ovf <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      a_r        <= '0;
      add_r      <= '0;
      xor_r      <= '0;
      tap_r      <= '0;
      gate_cnt   <= '0;
      settle_cnt <= '0;
      ring_en    <= 1'b0;
      ring_clr   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          ring_en  <= 1'b0;
          ring_clr <= 1'b1;
          if (start) begin
            a_r      <= input_a;
            add_r    <= add_enable;
            xor_r    <= xor_enable;
            tap_r    <= tap_sel;
            gate_cnt <= gate_cycles;
            busy     <= 1'b1;
            if (gate_cycles == '0) begin
              state      <= SETTLE;
              settle_cnt <= SET_W'(SETTLE_CYCLES);
            end else begin
              state    <= RUN;
              ring_en  <= 1'b1;
              ring_clr <= 1'b0;
            end
          end
        end
        RUN: begin
          if (gate_cnt == GATE_W'(1)) begin
            state      <= SETTLE;
            ring_en    <= 1'b0;
            settle_cnt <= SET_W'(SETTLE_CYCLES);
          end else begin
            gate_cnt <= gate_cnt - GATE_W'(1);
          end
        end
        SETTLE: begin
          if (settle_cnt <= SET_W'(1)) state <= CAPTURE;
          else                         settle_cnt <= settle_cnt - SET_W'(1);
        end
        CAPTURE: begin
          count    <= ring_cnt;
          overflow <= ring_ovf;
          done     <= 1'b1;
          busy     <= 1'b0;
          ring_clr <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instrumented_adder_counter.sv
// tb/tb_instrumented_adder_counter.sv - directed self-checking bench for instrumented_adder_counter
`timescale 1ns/1ps

module tb_instrumented_adder_counter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] gate_cycles = '0;
  logic [7:0]  input_a = 8'h01;
  logic [7:0]  add_enable = 8'hFF;
  logic [7:0]  xor_enable = 8'h00;
  logic [2:0]  tap_sel = 3'd0;
  logic        ext_osc = 1'b0;
  real         ext_half = 2.0;

  logic        busy, done, overflow;
  logic [15:0] count;
  logic [7:0]  outputs;
  logic        busy8, done8, overflow8;
  logic [7:0]  count8;
  logic [7:0]  outputs8;

  int tests = 0;
  int fails = 0;

  instrumented_adder_counter #(.COUNT_W(16), .USE_EXT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_cycles(gate_cycles),
    .input_a(input_a), .add_enable(add_enable), .xor_enable(xor_enable),
    .tap_sel(tap_sel), .ext_osc(ext_osc), .busy(busy), .done(done),
    .count(count), .overflow(overflow), .outputs(outputs)
  );

  instrumented_adder_counter #(.COUNT_W(8), .USE_EXT(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_cycles(gate_cycles),
    .input_a(input_a), .add_enable(add_enable), .xor_enable(xor_enable),
    .tap_sel(tap_sel), .ext_osc(ext_osc), .busy(busy8), .done(done8),
    .count(count8), .overflow(overflow8), .outputs(outputs8)
  );

  always #5 clk = ~clk;

  initial begin
    #0.3;
    forever #(ext_half) ext_osc = ~ext_osc;
  end

  // Runs one measurement; optionally re-pulses start (with another gate value) while busy.
  task automatic measure(input logic [15:0] g, input int restart_at, input logic [15:0] g2,
                         output int busy_cycles, output int done_seen, output bit timed_out);
    bit got;
    busy_cycles = 0;
    done_seen   = 0;
    got         = 1'b0;
    @(negedge clk);
    start = 1'b1;
    gate_cycles = g;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_seen++;
        got = 1'b1;
      end else begin
        if (i == restart_at) begin
          start = 1'b1;
          gate_cycles = g2;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    timed_out = !got;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %0b want 0", done); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    tests++; if (outputs !== 8'h00) begin fails++; $display("FAIL reset_outputs got %h want 00", outputs); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ring_idle;
    logic [7:0] a_vec [3] = '{8'h00, 8'h5A, 8'hFF};
    add_enable = 8'hA5;
    xor_enable = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      input_a = a_vec[i];
      repeat (4) @(negedge clk);
      tests++; if (outputs !== 8'h00) begin fails++; $display("FAIL idle_outputs[%0d] got %h want 00", i, outputs); end
      tests++; if (dut.ring_cnt !== 16'd0) begin fails++; $display("FAIL idle_ring_cnt[%0d] got %0d want 0", i, dut.ring_cnt); end
    end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %0b want 0", busy); end
    input_a = 8'h01;
    add_enable = 8'hFF;
    xor_enable = 8'h00;
  endtask

  task automatic test_basic_count;
    int bc, dn; bit to;
    measure(16'd100, -1, 16'd0, bc, dn, to);
    tests++; if (to) begin fails++; $display("FAIL basic_timeout got timeout want done"); end
    tests++; if (bc != 105) begin fails++; $display("FAIL basic_busy_cycles got %0d want 105", bc); end
    tests++; if (dn != 1) begin fails++; $display("FAIL basic_done_pulses got %0d want 1", dn); end
    tests++; if (count < 16'd249 || count > 16'd251) begin fails++; $display("FAIL basic_count got %0d want 250+-1", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL basic_overflow got %0b want 0", overflow); end
  endtask

  task automatic test_overflow;
    int bc, dn; bit to;
    ext_half = 1.0;
    measure(16'd100, -1, 16'd0, bc, dn, to);
    ext_half = 2.0;
    tests++; if (to) begin fails++; $display("FAIL ovf_timeout got timeout want done"); end
    tests++; if (count8 < 8'd243 || count8 > 8'd245) begin fails++; $display("FAIL ovf_count8 got %0d want 244+-1", count8); end
    tests++; if (overflow8 !== 1'b1) begin fails++; $display("FAIL ovf_flag8 got %0b want 1", overflow8); end
    tests++; if (count < 16'd499 || count > 16'd501) begin fails++; $display("FAIL ovf_count16 got %0d want 500+-1", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_flag16 got %0b want 0", overflow); end
  endtask

  task automatic test_gate_zero;
    int bc, dn; bit to;
    measure(16'd0, -1, 16'd0, bc, dn, to);
    tests++; if (to) begin fails++; $display("FAIL zero_timeout got timeout want done"); end
    tests++; if (bc != 5) begin fails++; $display("FAIL zero_busy_cycles got %0d want 5", bc); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL zero_count got %0d want 0", count); end
    tests++; if (overflow8 !== 1'b0) begin fails++; $display("FAIL zero_overflow8 got %0b want 0", overflow8); end
    tests++; if (dn != 1) begin fails++; $display("FAIL zero_done_pulses got %0d want 1", dn); end
  endtask

  task automatic test_start_while_busy;
    int bc, dn; bit to;
    measure(16'd100, 10, 16'd20, bc, dn, to);
    tests++; if (to) begin fails++; $display("FAIL busy_start_timeout got timeout want done"); end
    tests++; if (bc != 105) begin fails++; $display("FAIL busy_start_cycles got %0d want 105", bc); end
    tests++; if (dn != 1) begin fails++; $display("FAIL busy_start_done_pulses got %0d want 1", dn); end
    tests++; if (count < 16'd249 || count > 16'd251) begin fails++; $display("FAIL busy_start_count got %0d want 250+-1", count); end
  endtask

  task automatic test_reset_mid_run;
    int bc, dn; bit to;
    @(negedge clk);
    start = 1'b1;
    gate_cycles = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %0b want 0", busy); end
    tests++; if (count !== 16'd0) begin fails++; $display("FAIL midrst_count got %0d want 0", count); end
    tests++; if (outputs !== 8'h00) begin fails++; $display("FAIL midrst_outputs got %h want 00", outputs); end
    tests++; if (dut.ring_cnt !== 16'd0) begin fails++; $display("FAIL midrst_ring_cnt got %0d want 0", dut.ring_cnt); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL midrst_overflow got %0b want 0", overflow); end
    repeat (3) @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL midrst_done got %0b want 0", done); end
    rst_n = 1'b1;
    @(negedge clk);
    measure(16'd100, -1, 16'd0, bc, dn, to);
    tests++; if (to) begin fails++; $display("FAIL postrst_timeout got timeout want done"); end
    tests++; if (count < 16'd249 || count > 16'd251) begin fails++; $display("FAIL postrst_count got %0d want 250+-1", count); end
    tests++; if (dn != 1) begin fails++; $display("FAIL postrst_done_pulses got %0d want 1", dn); end
  endtask

  initial begin
    test_reset();
    test_ring_idle();
    test_basic_count();
    test_overflow();
    test_gate_zero();
    test_start_while_busy();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
